// File: rtl/interrupt_arbiter_if.sv
// Interrupt arbiter bus: source-side request/enable/ack lines plus the
// GC-side pending/taken/pc_capture handshake and the latched cause.
// master: the arbiter itself. slave: the surrounding CSR/GC logic.
interface interrupt_arbiter_if #(
  parameter int NUM_SOURCES = 8,
  parameter int CAUSE_W     = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
);
  logic [NUM_SOURCES-1:0] irq_src;
  logic [NUM_SOURCES-1:0] irq_enable;
  logic                   global_ie;
  logic                   processing_csr;
  logic                   interrupt_taken;
  logic                   interrupt_pc_capture;
  logic                   interrupt_pending;
  logic [CAUSE_W-1:0]     cause;
  logic                   cause_valid;
  logic [NUM_SOURCES-1:0] irq_ack;

  modport master (
    input  irq_src,
    input  irq_enable,
    input  global_ie,
    input  processing_csr,
    input  interrupt_taken,
    input  interrupt_pc_capture,
    output interrupt_pending,
    output cause,
    output cause_valid,
    output irq_ack
  );

  modport slave (
    output irq_src,
    output irq_enable,
    output global_ie,
    output processing_csr,
    output interrupt_taken,
    output interrupt_pc_capture,
    input  interrupt_pending,
    input  cause,
    input  cause_valid,
    input  irq_ack
  );
endinterface

// File: rtl/interrupt_arbiter.sv
// Fixed-priority interrupt arbiter (lowest index wins) feeding the GC unit.
// Raises a registered interrupt_pending with its cause, follows the
// taken -> pc_capture handshake, pulses a one-hot ack to the winner and
// then holds off new requests for MIN_GAP cycles.
// Optional: define INTERRUPT_ARBITER_EDGE_EN for sticky rising-edge request
// latches; left undefined the sources are level-sensitive.
module interrupt_arbiter #(
  parameter int NUM_SOURCES = 8,
  parameter int MIN_GAP     = 4,
  parameter int CAUSE_W     = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input logic                 clk,
  input logic                 rst,
  interrupt_arbiter_if.master bus
);

  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    WAIT_CAPTURE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   pending_q;
  logic                   pending_next;
  logic [CAUSE_W-1:0]     cause_q;
  logic [CAUSE_W-1:0]     cause_next;
  logic                   cause_valid_q;
  logic                   cause_valid_next;
  logic [NUM_SOURCES-1:0] ack_q;
  logic [NUM_SOURCES-1:0] ack_next;
  logic [GAP_W-1:0]       gap_q;
  logic [GAP_W-1:0]       gap_next;

  logic [NUM_SOURCES-1:0] req_vec;
  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] cause_oh;
  logic [CAUSE_W-1:0]     winner;
  logic                   cause_live;

`ifdef INTERRUPT_ARBITER_EDGE_EN
  logic [NUM_SOURCES-1:0] src_prev;
  logic [NUM_SOURCES-1:0] edge_latch;

  // Sticky rising-edge latches; an ack clears its bit unless a fresh edge arrives at the same time
  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev   <= '0;
      edge_latch <= '0;
    end else begin
      src_prev   <= bus.irq_src;
      edge_latch <= (edge_latch & ~ack_next) | (bus.irq_src & ~src_prev);
    end
  end

  assign req_vec = edge_latch;
`else
  assign req_vec = bus.irq_src;
`endif

  assign eligible = req_vec & bus.irq_enable & {NUM_SOURCES{bus.global_ie}};

  // Lowest-index eligible source wins; scanning downward lets lower indices overwrite
  always_comb begin
    winner = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (eligible[i]) winner = CAUSE_W'(i);
    end
  end

  // One-hot of the latched cause, used both for the withdraw test and the ack
  always_comb begin
    cause_oh = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      cause_oh[i] = (cause_q == CAUSE_W'(i));
    end
  end

  assign cause_live = |(eligible & cause_oh);

  // Next-state and next-output decisions for the request/handshake FSM
  always_comb begin
    state_next       = state;
    pending_next     = pending_q;
    cause_next       = cause_q;
    cause_valid_next = cause_valid_q;
    ack_next         = '0;
    gap_next         = gap_q;
    case (state)
      IDLE: begin
        if (gap_q != '0) gap_next = gap_q - GAP_W'(1);
        if ((|eligible) && !bus.processing_csr && (gap_q == '0)) begin
          state_next       = PENDING;
          pending_next     = 1'b1;
          cause_next       = winner;
          cause_valid_next = 1'b1;
        end
      end
      PENDING: begin
        if (bus.interrupt_taken && bus.interrupt_pc_capture) begin
          state_next       = IDLE;
          pending_next     = 1'b0;
          cause_valid_next = 1'b0;
          ack_next         = cause_oh;
          gap_next         = GAP_LOAD;
        end else if (bus.interrupt_taken) begin
          state_next   = WAIT_CAPTURE;
          pending_next = 1'b0;
        end else if (!cause_live) begin
          state_next       = IDLE;
          pending_next     = 1'b0;
          cause_valid_next = 1'b0;
        end
      end
      WAIT_CAPTURE: begin
        if (bus.interrupt_pc_capture) begin
          state_next       = IDLE;
          cause_valid_next = 1'b0;
          ack_next         = cause_oh;
          gap_next         = GAP_LOAD;
        end
      end
      default: begin
        state_next       = IDLE;
        pending_next     = 1'b0;
        cause_valid_next = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight interrupt without an ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pending_q     <= 1'b0;
      cause_q       <= '0;
      cause_valid_q <= 1'b0;
      ack_q         <= '0;
      gap_q         <= '0;
    end else begin
      state         <= state_next;
      pending_q     <= pending_next;
      cause_q       <= cause_next;
      cause_valid_q <= cause_valid_next;
      ack_q         <= ack_next;
      gap_q         <= gap_next;
    end
  end

  assign bus.interrupt_pending = pending_q;
  assign bus.cause             = cause_q;
  assign bus.cause_valid       = cause_valid_q;
  assign bus.irq_ack           = ack_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Scoreboard bench for interrupt_arbiter. Stimulus pushes expected output
// events (pending rise, taken, ack, withdraw) with the cycle they must appear;
// a negedge monitor pops and compares whenever the DUT shows an event.
// dut_a uses MIN_GAP=4, dut_b uses MIN_GAP=0.
module tb_interrupt_arbiter;

  localparam int EV_PEND  = 1;
  localparam int EV_TAKEN = 2;
  localparam int EV_ACK   = 3;
  localparam int EV_DROP  = 4;

  typedef struct {
    int kind;
    int value;
    int cycle;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  ev_t exp_a[$];
  ev_t exp_b[$];
  bit  prev_pend [2];
  bit  prev_cv   [2];

  interrupt_arbiter_if #(.NUM_SOURCES(8)) bus_a ();
  interrupt_arbiter_if #(.NUM_SOURCES(8)) bus_b ();

  interrupt_arbiter #(.NUM_SOURCES(8), .MIN_GAP(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  interrupt_arbiter #(.NUM_SOURCES(8), .MIN_GAP(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] src, input logic [7:0] en,
                               input logic gie, input logic csr, input logic taken,
                               input logic cap);
    if (id == 0) begin
      bus_a.irq_src = src; bus_a.irq_enable = en; bus_a.global_ie = gie;
      bus_a.processing_csr = csr; bus_a.interrupt_taken = taken;
      bus_a.interrupt_pc_capture = cap;
    end else begin
      bus_b.irq_src = src; bus_b.irq_enable = en; bus_b.global_ie = gie;
      bus_b.processing_csr = csr; bus_b.interrupt_taken = taken;
      bus_b.interrupt_pc_capture = cap;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  task automatic expect_event(input int id, input int kind, input int value, input int at);
    ev_t e;
    e.kind = kind; e.value = value; e.cycle = at;
    if (id == 0) exp_a.push_back(e);
    else exp_b.push_back(e);
  endtask

  task automatic score_event(input int id, input int kind, input int value);
    ev_t e;
    string nm;
    nm = (id == 0) ? "A" : "B";
    checks++;
    if (id == 0 && exp_a.size() > 0) e = exp_a.pop_front();
    else if (id == 1 && exp_b.size() > 0) e = exp_b.pop_front();
    else begin
      $display("[TB] FAIL unexpected_event_%s: got kind=%0d value=0x%0h cycle=%0d, required no event",
               nm, kind, value, cyc);
      return;
    end
    if (e.kind == kind && e.value == value && e.cycle == cyc) passes++;
    else $display("[TB] FAIL event_%s: got kind=%0d value=0x%0h cycle=%0d, required kind=%0d value=0x%0h cycle=%0d",
                  nm, kind, value, cyc, e.kind, e.value, e.cycle);
  endtask

  task automatic observe(input int id, input logic pend, input logic [2:0] cause,
                         input logic cv, input logic [7:0] ack);
    if (pend === 1'b1 && !prev_pend[id]) score_event(id, EV_PEND, int'(cause));
    if (pend === 1'b0 && prev_pend[id] && cv === 1'b1) score_event(id, EV_TAKEN, 0);
    if ((|ack) === 1'b1) score_event(id, EV_ACK, int'(ack));
    else if (cv === 1'b0 && prev_cv[id]) score_event(id, EV_DROP, 0);
    prev_pend[id] = (pend === 1'b1);
    prev_cv[id]   = (cv === 1'b1);
  endtask

  // Monitor: watch both DUTs away from the active edge and score every event
  always @(negedge clk) begin
    observe(0, bus_a.interrupt_pending, bus_a.cause, bus_a.cause_valid, bus_a.irq_ack);
    observe(1, bus_b.interrupt_pending, bus_b.cause, bus_b.cause_valid, bus_b.irq_ack);
  end

  // Directed stimulus with hand-computed event cycles
  initial begin
    int t;
    ev_t e;
    rst = 1'b1;
    applyStimulus(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cycles(3);
    checkOutput("rst_pending_a", 32'(bus_a.interrupt_pending), 32'h0);
    checkOutput("rst_cause_a",   32'(bus_a.cause),             32'h0);
    checkOutput("rst_cv_a",      32'(bus_a.cause_valid),       32'h0);
    checkOutput("rst_ack_a",     32'(bus_a.irq_ack),           32'h0);
    checkOutput("rst_pending_b", 32'(bus_b.interrupt_pending), 32'h0);
    checkOutput("rst_cause_b",   32'(bus_b.cause),             32'h0);
    checkOutput("rst_cv_b",      32'(bus_b.cause_valid),       32'h0);
    checkOutput("rst_ack_b",     32'(bus_b.irq_ack),           32'h0);
    rst = 1'b0;

`ifdef INTERRUPT_ARBITER_EDGE_EN
    // one-cycle pulse on source 3: latched, then cleared by its ack
    wait_cycles(1); t = cyc;
    applyStimulus(0, 8'h08, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(0, EV_PEND, 3, t + 2);
    wait_cycles(1);
    applyStimulus(0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cycles(1);
    applyStimulus(0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_event(0, EV_ACK, 8'h08, t + 3);
    wait_cycles(1);
    applyStimulus(0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cycles(8);
    checkOutput("edge_no_rerequest_pending", 32'(bus_a.interrupt_pending), 32'h0);
    checkOutput("edge_no_rerequest_cv",      32'(bus_a.cause_valid),       32'h0);
`else
    // sources 5 and 2: cause 2, taken, capture two cycles later, then gap of 4
    wait_cycles(1); t = cyc;
    applyStimulus(0, 8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(0, EV_PEND, 2, t + 1);
    wait_cycles(1);
    applyStimulus(0, 8'h24, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_event(0, EV_TAKEN, 0, t + 2);
    wait_cycles(1);
    applyStimulus(0, 8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cycles(1);
    applyStimulus(0, 8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_event(0, EV_ACK, 8'h04, t + 4);
    wait_cycles(1);
    applyStimulus(0, 8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(0, EV_PEND, 2, t + 9);
    // global_ie drops while pending: withdraw, no ack
    wait_cycles(5);
    applyStimulus(0, 8'h24, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_event(0, EV_DROP, 0, t + 10);
    wait_cycles(3);

    // processing_csr blocks the request; taken+capture together acks next cycle
    t = cyc;
    applyStimulus(0, 8'h24, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_cycles(4);
    applyStimulus(0, 8'h24, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(0, EV_PEND, 2, t + 5);
    wait_cycles(1);
    applyStimulus(0, 8'h24, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_event(0, EV_ACK, 8'h04, t + 6);
    wait_cycles(1);
    applyStimulus(0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    // taken/capture in IDLE are ignored
    wait_cycles(5);
    applyStimulus(0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_cycles(1);
    applyStimulus(0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cycles(2);

    // no preemption by source 1; capture without taken ignored in PENDING
    t = cyc;
    applyStimulus(0, 8'h40, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(0, EV_PEND, 6, t + 1);
    wait_cycles(1);
    applyStimulus(0, 8'h42, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_cycles(1);
    checkOutput("no_preempt_cause",   32'(bus_a.cause),             32'h6);
    checkOutput("no_preempt_pending", 32'(bus_a.interrupt_pending), 32'h1);
    applyStimulus(0, 8'h42, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_event(0, EV_TAKEN, 0, t + 3);
    wait_cycles(1);
    applyStimulus(0, 8'h42, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_event(0, EV_ACK, 8'h40, t + 4);
    wait_cycles(1);
    applyStimulus(0, 8'h42, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(0, EV_PEND, 1, t + 9);
    wait_cycles(5);
    applyStimulus(0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(0, EV_DROP, 0, t + 10);
    wait_cycles(3);

    // reset while waiting for capture: everything clears, no ack
    t = cyc;
    applyStimulus(0, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(0, EV_PEND, 7, t + 1);
    wait_cycles(1);
    applyStimulus(0, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_event(0, EV_TAKEN, 0, t + 2);
    wait_cycles(1);
    applyStimulus(0, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    expect_event(0, EV_DROP, 0, t + 3);
    wait_cycles(1);
    rst = 1'b0;
    applyStimulus(0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_pending", 32'(bus_a.interrupt_pending), 32'h0);
    checkOutput("midrst_cause",   32'(bus_a.cause),             32'h0);
    checkOutput("midrst_cv",      32'(bus_a.cause_valid),       32'h0);
    checkOutput("midrst_ack",     32'(bus_a.irq_ack),           32'h0);
    wait_cycles(4);

    // MIN_GAP=0: source 0 held, re-raised the cycle after the ack
    t = cyc;
    applyStimulus(1, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(1, EV_PEND, 0, t + 1);
    wait_cycles(1);
    applyStimulus(1, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_event(1, EV_ACK, 8'h01, t + 2);
    wait_cycles(1);
    applyStimulus(1, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(1, EV_PEND, 0, t + 3);
    wait_cycles(1);
    applyStimulus(1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_event(1, EV_DROP, 0, t + 4);
    wait_cycles(3);
`endif

    wait_cycles(10);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      checks++;
      $display("[TB] FAIL missing_event_A: got nothing, required kind=%0d value=0x%0h cycle=%0d",
               e.kind, e.value, e.cycle);
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      $display("[TB] FAIL missing_event_B: got nothing, required kind=%0d value=0x%0h cycle=%0d",
               e.kind, e.value, e.cycle);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
Name: interrupt_arbiter

Overview:
Arbitrates among NUM_SOURCES interrupt request lines. Presents a single registered interrupt request, with its cause index, to the global control unit. Tracks the GC handshake (taken, then PC capture) and returns a one-cycle acknowledge to the winning source. Enforces a minimum gap between consecutive interrupts so the core always makes forward progress. Sits between the CSR/interrupt-source logic and the GC unit's interrupt_pending / interrupt_taken / interrupt_pc_capture ports.

Parameters:
NUM_SOURCES, 8, number of interrupt request lines (1..32)
MIN_GAP, 4, cycles after an acknowledge during which no new request is raised; 0 disables the gap
CAUSE_W, $clog2(NUM_SOURCES) (minimum 1), width of the cause index

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
irq_src  in  NUM_SOURCES  raw interrupt request lines
irq_enable  in  NUM_SOURCES  per-source enable (mie-style, from CSR)
global_ie  in  1  global interrupt enable (mstatus.MIE-style)
processing_csr  in  1  CSR op in flight; blocks raising a new request
interrupt_taken  in  1  GC accepted the request (one-cycle pulse)
interrupt_pc_capture  in  1  GC captured the return PC (one-cycle pulse)
interrupt_pending  out  1  request to GC, registered
cause  out  CAUSE_W  index of the latched winning source, registered
cause_valid  out  1  cause holds a live interrupt (PENDING or WAIT_CAPTURE)
irq_ack  out  NUM_SOURCES  one-hot, one-cycle acknowledge to the winning source

Behaviour:
- Reset: state=IDLE; interrupt_pending=0, cause=0, cause_valid=0, irq_ack=0, gap counter=0, edge latches=0. Reset mid-operation abandons any pending or captured interrupt and sends no ack.
- eligible = req_vec & irq_enable & {NUM_SOURCES{global_ie}}. req_vec = irq_src (level mode) or the edge latches (edge mode).
- Priority is fixed: the lowest index wins.
- IDLE:
  - If |eligible, !processing_csr and gap==0: latch the winner into cause, set cause_valid and interrupt_pending, go to PENDING.
  - Latency: eligible at edge t gives interrupt_pending=1 after edge t+1.
  - gap decrements by 1 each IDLE cycle while nonzero; it saturates at 0.
- PENDING:
  - interrupt_pending=1. The winner is held; there is no preemption by a higher-priority source that arrives later.
  - interrupt_taken=1: go to WAIT_CAPTURE and deassert interrupt_pending next cycle.
  - Otherwise, if eligible[cause]==0 (source dropped, disabled, or global_ie=0): withdraw. Go to IDLE, clear interrupt_pending and cause_valid, send no ack.
  - interrupt_taken wins over a simultaneous withdrawal.
- WAIT_CAPTURE:
  - interrupt_pending=0, cause_valid=1.
  - interrupt_pc_capture=1: on the next cycle pulse irq_ack[cause] for one cycle, clear cause_valid, load gap=MIN_GAP, go to IDLE.
  - No timeout. Source changes are ignored in this state.
- interrupt_taken and interrupt_pc_capture in the same PENDING cycle: go directly to the ack, skipping WAIT_CAPTURE.
- interrupt_pc_capture while in IDLE or PENDING (without taken) is ignored. interrupt_taken while in IDLE is ignored.
- The cycle an ack issues counts as the first gap cycle. Exactly MIN_GAP cycles later, a new request may be raised.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
INTERRUPT_ARBITER_EDGE_EN:
- Defined: each source has a sticky latch, set on a rising edge of irq_src (registered previous value). The latch is cleared by irq_ack to that source. The edge detect register resets to 0, so a line high at reset deassertion counts as an edge. A new edge in the same cycle as the ack keeps the latch set. Withdrawal in PENDING can then occur only via irq_enable or global_ie.
- Undefined: level-sensitive; req_vec = irq_src directly, and no edge logic is synthesized.

Test Plan:
- Level mode, sources 5 and 2 high, all enabled, global_ie=1 -> interrupt_pending after 1 edge, cause=2. Send taken, then capture 2 cycles later -> irq_ack=0x04 for exactly 1 cycle.
- Request raised with processing_csr=1 -> no interrupt_pending while it is held. processing_csr drops -> pending appears 1 cycle later.
- In PENDING, global_ie drops before taken -> interrupt_pending=0 and cause_valid=0 next cycle, irq_ack never asserts.
- MIN_GAP=4, source 0 held high continuously -> after the ack, the next interrupt_pending rises exactly 5 cycles after the ack cycle. MIN_GAP=0 -> rises the cycle after the ack.
- taken and capture in the same cycle -> irq_ack next cycle. Assert rst while in WAIT_CAPTURE -> all outputs 0 next cycle, no ack.
- INTERRUPT_ARBITER_EDGE_EN: pulse irq_src[3] for 1 cycle -> pending, cause=3. Ack clears the latch, and there is no re-request while the line stays low.
